// File: rtl/rv_pkg.sv
// Shared pipeline definitions: opcodes, hazard FSM encoding, stage tracker record
// and the opcode decode used by the hazard logic.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        ERR     = 2'b10
    } hz_state_e;

    typedef enum logic [1:0] {
        TRK_HOLD    = 2'b00,
        TRK_BUBBLE  = 2'b01,
        TRK_ADVANCE = 2'b10
    } trk_ctl_e;

    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic       is_store;
        logic [4:0] rd;
    } stage_trk_t;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic use1;
        logic use2;
    } op_dec_t;

    localparam stage_trk_t STAGE_BUBBLE = stage_trk_t'(8'h00);

    function automatic op_dec_t decode_op(input logic [6:0] op);
        op_dec_t d;
        case (op)
            OP_LOAD:   d = '{is_load: 1'b1, is_store: 1'b0, use1: 1'b1, use2: 1'b0};
            OP_STORE:  d = '{is_load: 1'b0, is_store: 1'b1, use1: 1'b1, use2: 1'b1};
            OP_RTYPE:  d = '{is_load: 1'b0, is_store: 1'b0, use1: 1'b1, use2: 1'b1};
            OP_BRANCH: d = '{is_load: 1'b0, is_store: 1'b0, use1: 1'b1, use2: 1'b1};
            OP_ITYPE:  d = '{is_load: 1'b0, is_store: 1'b0, use1: 1'b1, use2: 1'b0};
            default:   d = '{is_load: 1'b0, is_store: 1'b0, use1: 1'b0, use2: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_stage_tracker.sv
// Shadow copies of the EX and MEM stage opcode class and rd, advanced in step
// with the real pipeline registers, plus operand-use decode of the ID opcode.
module hazard_stage_tracker
    import rv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  trk_ctl_e   ctl,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rd,
    input  logic       id_valid,
    output stage_trk_t ex,
    output stage_trk_t mem,
    output logic       use1,
    output logic       use2
);

    stage_trk_t ex_r;
    stage_trk_t mem_r;
    stage_trk_t id_trk_s;
    op_dec_t    dec_s;

    // Decode the ID instruction into the record EX will hold next cycle.
    always_comb begin
        dec_s    = decode_op(id_opcode);
        id_trk_s = '{valid: id_valid, is_load: dec_s.is_load,
                     is_store: dec_s.is_store, rd: id_rd};
        use1     = dec_s.use1;
        use2     = dec_s.use2;
    end

    // Tracker registers: hold on freeze, inject a bubble into EX, or advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r  <= STAGE_BUBBLE;
            mem_r <= STAGE_BUBBLE;
        end else begin
            case (ctl)
                TRK_HOLD: begin
                    ex_r  <= ex_r;
                    mem_r <= mem_r;
                end
                TRK_BUBBLE: begin
                    ex_r  <= STAGE_BUBBLE;
                    mem_r <= ex_r;
                end
                TRK_ADVANCE: begin
                    ex_r  <= id_trk_s;
                    mem_r <= ex_r;
                end
                default: begin
                    ex_r  <= ex_r;
                    mem_r <= mem_r;
                end
            endcase
        end
    end

    assign ex  = ex_r;
    assign mem = mem_r;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush and data-memory
// freeze with a wait watchdog, plus a saturating stall-cycle counter.
module hazard_stall_unit
    import rv_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_valid,
    input  logic             ex_branch_taken,
    input  logic             dmem_ready,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

    hz_state_e        state_r, state_nxt_s;
    logic [WC_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;
    stage_trk_t       ex_s, mem_s;
    logic             use1_s, use2_s;
    logic             load_use_s, mem_busy_s, freeze_s, event_s;
    trk_ctl_e         trk_ctl_s;

    hazard_stage_tracker u_trk (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctl       (trk_ctl_s),
        .id_opcode (id_opcode),
        .id_rd     (id_rd),
        .id_valid  (id_valid),
        .ex        (ex_s),
        .mem       (mem_s),
        .use1      (use1_s),
        .use2      (use2_s)
    );

    // Hazard conditions; in MEMWAIT the MEM tracker still holds the stalled access.
    always_comb begin
        load_use_s = id_valid & ex_s.valid & ex_s.is_load & (ex_s.rd != 5'd0) &
                     ((use1_s & (id_rs1 == ex_s.rd)) | (use2_s & (id_rs2 == ex_s.rd)));
        mem_busy_s = mem_s.valid & (mem_s.is_load | mem_s.is_store) & ~dmem_ready;
        freeze_s   = (state_r == ERR) | mem_busy_s;
    end

    // Priority mux: freeze > branch flush > load-use > normal.
    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        trk_ctl_s   = TRK_ADVANCE;
        event_s     = 1'b0;
        if (freeze_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            trk_ctl_s   = TRK_HOLD;
            event_s     = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            trk_ctl_s  = TRK_BUBBLE;
            event_s    = 1'b1;
        end else if (load_use_s) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            trk_ctl_s  = TRK_BUBBLE;
            event_s    = 1'b1;
        end else begin
            trk_ctl_s = TRK_ADVANCE;
        end
    end

    // Memory-wait FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (mem_busy_s) state_nxt_s = MEMWAIT;
                else            state_nxt_s = RUN;
            end
            MEMWAIT: begin
                if (dmem_ready)                   state_nxt_s = RUN;
                else if (wait_cnt_r == WAIT_LAST) state_nxt_s = ERR;
                else                              state_nxt_s = MEMWAIT;
            end
            ERR:     state_nxt_s = ERR;
            default: state_nxt_s = RUN;
        endcase
    end

    // State register and wait watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            wait_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == RUN) begin
                wait_cnt_r <= '0;
            end else if (state_r == MEMWAIT) begin
                wait_cnt_r <= wait_cnt_r + WC_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Saturating count of freeze, flush and bubble cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (event_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign mem_err   = (state_r == ERR);
    assign stall_cnt = stall_cnt_r;

endmodule
